// File: rtl/axi_wr_arb_2x1.sv
// Two-requester arbiter for one downstream AXI write port, one transaction in flight; AXI_WR_ARB_FIXED_PRIO_EN selects fixed priority and stray-BID draining.
// AW is registered (1 cycle to M_AWVALID); W and B pass through combinationally; a loser or early W is held off with ready=0.
module axi_wr_arb_2x1 #(
    parameter int         DATA_W = 1024,
    parameter logic [2:0] SIZE   = 3'd7
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [1:0][31:0]       S_AWADDR,
    input  logic [1:0][7:0]        S_AWLEN,
    input  logic [1:0]             S_AWVALID,
    output logic [1:0]             S_AWREADY,
    input  logic [1:0][DATA_W-1:0] S_WDATA,
    input  logic [1:0]             S_WLAST,
    input  logic [1:0]             S_WVALID,
    output logic [1:0]             S_WREADY,
    output logic [1:0]             S_BRESP,
    output logic [1:0]             S_BVALID,
    input  logic [1:0]             S_BREADY,
    output logic                   M_AWID,
    output logic [31:0]            M_AWADDR,
    output logic [7:0]             M_AWLEN,
    output logic [2:0]             M_AWSIZE,
    output logic [1:0]             M_AWBURST,
    output logic                   M_AWVALID,
    input  logic                   M_AWREADY,
    output logic                   M_WID,
    output logic [DATA_W-1:0]      M_WDATA,
    output logic                   M_WLAST,
    output logic                   M_WVALID,
    input  logic                   M_WREADY,
    input  logic                   M_BID,
    input  logic [1:0]             M_BRESP,
    input  logic                   M_BVALID,
    output logic                   M_BREADY
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic        g_q, g_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        win;
    logic [1:0]  awready_c;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
    assign win = S_AWVALID[0] ? 1'b0 : 1'b1;
`else
    logic ptr_q, ptr_d;
    logic unused_bid;
    assign unused_bid = M_BID;
    assign win = S_AWVALID[ptr_q] ? ptr_q : ~ptr_q;
`endif

    assign M_AWID    = g_q;
    assign M_WID     = g_q;
    assign M_AWADDR  = awaddr_q;
    assign M_AWLEN   = awlen_q;
    assign M_AWSIZE  = SIZE;
    assign M_AWBURST = 2'b01;
    assign M_WDATA   = S_WDATA[g_q];
    assign M_WLAST   = S_WLAST[g_q];
    assign S_BRESP   = M_BRESP;
    // The requester accept is combinational, so it must be masked while reset holds the FSM.
    assign S_AWREADY = awready_c & {2{ARESETN}};

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        awready_c = 2'b00;
        S_WREADY  = 2'b00;
        S_BVALID  = 2'b00;
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|S_AWVALID) begin
                    awready_c[win] = 1'b1;
                    g_d            = win;
                    awaddr_d       = S_AWADDR[win];
                    awlen_d        = S_AWLEN[win];
                    state_d        = ADDR;
                end
            end
            ADDR: begin
                M_AWVALID = 1'b1;
                if (M_AWREADY) state_d = DATA;
            end
            DATA: begin
                M_WVALID      = S_WVALID[g_q];
                S_WREADY[g_q] = M_WREADY;
                if (S_WVALID[g_q] && M_WREADY && S_WLAST[g_q]) state_d = RESP;
            end
            RESP: begin
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
                if (M_BID != g_q) begin
                    M_BREADY = 1'b1;
                end else begin
                    S_BVALID[g_q] = M_BVALID;
                    M_BREADY      = S_BREADY[g_q];
                    if (M_BVALID && S_BREADY[g_q]) state_d = IDLE;
                end
`else
                S_BVALID[g_q] = M_BVALID;
                M_BREADY      = S_BREADY[g_q];
                if (M_BVALID && S_BREADY[g_q]) begin
                    state_d = IDLE;
                    ptr_d   = ~g_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            g_q      <= 1'b0;
            awaddr_q <= 32'd0;
            awlen_q  <= 8'd0;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

endmodule

// File: doc/axi_wr_arb_2x1.md
Name: axi_wr_arb_2x1

Overview:
- Two-requester arbiter sharing one downstream AXI write port (AW/W/B channels) between requesters S[0] and S[1].
- Sits between two write masters (e.g. DMA engines) and a single AXI slave.
- Exactly one write transaction is outstanding at a time: address, then the data burst, then the response, after which the port is re-arbitrated.
- Round-robin arbitration by default.

Parameters:
- DATA_W, 1024, width of WDATA.
- SIZE, 3'd7, constant driven on M_AWSIZE (log2 of bytes per beat).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- S_AWADDR  in  2x32  per-requester write address; index i is requester i.
- S_AWLEN  in  2x8  per-requester burst length minus 1.
- S_AWVALID  in  2  per-requester address valid.
- S_AWREADY  out  2  per-requester address accept.
- S_WDATA  in  2xDATA_W  per-requester write data.
- S_WLAST  in  2  per-requester last beat.
- S_WVALID  in  2  per-requester data valid.
- S_WREADY  out  2  per-requester data ready.
- S_BRESP  out  2  response code, common to both requesters.
- S_BVALID  out  2  per-requester response valid.
- S_BREADY  in  2  per-requester response ready.
- M_AWID  out  1  index of the granted requester.
- M_AWADDR  out  32  registered copy of the granted address.
- M_AWLEN  out  8  registered copy of the granted length.
- M_AWSIZE  out  3  constant SIZE.
- M_AWBURST  out  2  constant 2'b01 (INCR).
- M_AWVALID  out  1  downstream address valid.
- M_AWREADY  in  1  downstream address ready.
- M_WID  out  1  equal to the grant index.
- M_WDATA  out  DATA_W  data of the granted requester.
- M_WLAST  out  1  last flag of the granted requester.
- M_WVALID  out  1  data valid of the granted requester.
- M_WREADY  in  1  downstream data ready.
- M_BID  in  1  response ID; ignored unless AXI_WR_ARB_FIXED_PRIO_EN is set.
- M_BRESP  in  2  downstream response code.
- M_BVALID  in  1  downstream response valid.
- M_BREADY  out  1  downstream response ready.

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - State IDLE; grant g=0; round-robin pointer ptr=0.
  - M_AWVALID, M_WVALID, M_BREADY, S_AWREADY, S_WREADY, S_BVALID all 0.
  - M_AWADDR=0, M_AWLEN=0, M_BRESP passthrough.
  - Reset during any state aborts the transaction; no completion is signalled.
- FSM states: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - If any S_AWVALID is set, winner w is: ptr if S_AWVALID[ptr], else the other requester.
  - S_AWREADY[w]=1 combinationally in that cycle, so the requester handshake completes.
  - On that edge: g<=w, M_AWADDR/M_AWLEN<=S_AWADDR[w]/S_AWLEN[w], state<=ADDR.
  - The loser's S_AWREADY stays 0.
- ADDR:
  - M_AWVALID=1; fields stay stable until M_AWREADY.
  - The edge with M_AWREADY=1 moves the FSM to DATA.
  - Latency from requester AW handshake to M_AWVALID is 1 cycle.
- DATA: combinational passthrough.
  - M_WVALID=S_WVALID[g]; M_WDATA and M_WLAST from requester g.
  - S_WREADY[g]=M_WREADY; S_WREADY of the other requester is 0.
  - A W handshake with M_WLAST=1 moves the FSM to RESP.
  - Beats are not counted; WLAST is authoritative.
- RESP:
  - S_BVALID[g]=M_BVALID; S_BRESP=M_BRESP on both lanes; M_BREADY=S_BREADY[g].
  - The B handshake moves the FSM to IDLE and sets ptr<=~g.
- Outside their own state, all channel valids and readies are 0.
- Minimum of one IDLE cycle between transactions.
- W beats offered by a requester before its grant are held off (ready=0); no data is buffered.
- Requesters must keep AWVALID asserted until AWREADY is seen (AXI rule). A losing request therefore waits at most one full transaction.

Optional Feature:
- Macro: AXI_WR_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins when both S_AWVALID bits are set; ptr is unused.
  - In RESP, a B handshake with M_BID!=g is not forwarded: S_BVALID stays 0 and M_BREADY=1 drains it.
- Undefined: round-robin as above; M_BID is ignored.

Test Plan:
- Single write from S1:
  - Stimulus: AWADDR=0x1000, AWLEN=3, 4 beats, M_AWREADY and M_WREADY held 1, BRESP=OKAY.
  - Required: M_AWVALID one cycle after S_AWREADY[1], M_AWID=1, M_AWBURST=01, 4 W beats forwarded, S_BVALID[1]=1 with BRESP=00, FSM back to IDLE.
- Simultaneous requests after reset:
  - Stimulus: S0 and S1 both request, AWLEN=0.
  - Required: S0 served first, then S1; next simultaneous pair again served S0 first (ptr toggled to 1, then back to 0).
- Backpressure:
  - Stimulus: M_AWREADY low for 5 cycles, then M_WREADY toggling 1/0 over an 8-beat burst.
  - Required: AW fields stable throughout; exactly 8 beats transferred; S0_WREADY mirrors M_WREADY.
- Early W from the losing requester:
  - Stimulus: S1 drives WVALID while S0 owns the port.
  - Required: S1 WREADY=0 and M_WDATA equals S0 data until S1 is granted.
- Reset mid-DATA:
  - Stimulus: ARESETN pulsed low after beat 2 of 4.
  - Required: all valids 0 immediately, FSM IDLE, ptr=0, S1 next grant succeeds.
- With AXI_WR_ARB_FIXED_PRIO_EN:
  - Stimulus: continuous S0 and S1 requests; separately, a stray BID=1 while g=0.
  - Required: S0 wins every arbitration; the stray response is drained with S_BVALID=0.
